// File: rtl/id_ex_pkg.sv
// Shared types and constants for the elastic ID/EX stage of the 16-bit MIPS core.
package id_ex_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int ALU_CTRL_W = 3;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

    typedef struct packed {
        logic [DATA_W-1:0]     data1;
        logic [DATA_W-1:0]     data2;
        logic [DATA_W-1:0]     sign_ext;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [ALU_CTRL_W-1:0] alu_control;
        id_ex_ctrl_t           ctrl;
    } id_ex_payload_t;

    localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '0;

    // Bit 1 is the skid valid, bit 0 the main valid, so both come straight off the state flops.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

    // A bubble must look like a NOP downstream; alu_src only steers the ALU mux and is left alone.
    function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t c, input logic valid);
        id_ex_ctrl_t g;
        g         = valid ? c : ID_EX_CTRL_NOP;
        g.alu_src = c.alu_src;
        return g;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; in_ready_o is a flop output, so no ready path crosses it.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    import id_ex_pkg::*;

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, drain;

    assign in_ready_o  = ~state_q[1];
    assign out_valid_o = state_q[0];
    assign out_data_o  = main_q;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clear_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d = SKID_ONE;
                        main_d  = in_data_i;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = SKID_FULL;
                        skid_d  = in_data_i;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (drain) begin
                        state_d = SKID_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // NOTE: payload registers are reset too, so outputs read all-zero after reset rather than X.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/id_ex_stage_buf.sv
// Elastic ID/EX stage: packs decode outputs into a skid buffer, adds flush, occupancy and NOP gating.
module id_ex_stage_buf #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     reg_data1_in,
    input  logic [DATA_W-1:0]     reg_data2_in,
    input  logic [DATA_W-1:0]     sign_ext_in,
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [REG_ADDR_W-1:0] rt_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [ALU_CTRL_W-1:0] alu_control_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  alu_src_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     reg_data1_out,
    output logic [DATA_W-1:0]     reg_data2_out,
    output logic [DATA_W-1:0]     sign_ext_out,
    output logic [REG_ADDR_W-1:0] rs_out,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [ALU_CTRL_W-1:0] alu_control_out,
    output logic                  reg_write_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  mem_to_reg_out,
    output logic                  alu_src_out,
    output logic [1:0]            occupancy
);
    import id_ex_pkg::*;

    localparam int PAYLOAD_W = 3 * DATA_W + 3 * REG_ADDR_W + ALU_CTRL_W + CTRL_W;

    id_ex_ctrl_t          ctrl_in, ctrl_held, ctrl_gated;
    logic [PAYLOAD_W-1:0] payload_in, payload_out;

    assign ctrl_in = '{reg_write:  reg_write_in,
                       mem_read:   mem_read_in,
                       mem_write:  mem_write_in,
                       mem_to_reg: mem_to_reg_in,
                       alu_src:    alu_src_in};

    assign payload_in = {reg_data1_in, reg_data2_in, sign_ext_in,
                         rs_in, rt_in, rd_in, alu_control_in, ctrl_in};

    pipe_skid_buf #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk        (clk),
        .reset_ni   (reset),
        .clear_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (payload_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (payload_out)
    );

    assign {reg_data1_out, reg_data2_out, sign_ext_out,
            rs_out, rt_out, rd_out, alu_control_out, ctrl_held} = payload_out;

    assign ctrl_gated     = gate_ctrl(ctrl_held, out_valid);
    assign reg_write_out  = ctrl_gated.reg_write;
    assign mem_read_out   = ctrl_gated.mem_read;
    assign mem_write_out  = ctrl_gated.mem_write;
    assign mem_to_reg_out = ctrl_gated.mem_to_reg;
    assign alu_src_out    = ctrl_gated.alu_src;

    // Skid valid is the inverse of in_ready; FULL=2, ONE=1, EMPTY=0.
    assign occupancy = {~in_ready, out_valid & in_ready};

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed bench for id_ex_stage_buf: per-cycle vector table plus reset-mid-stall and FIFO-order sequences.
module tb_id_ex_stage_buf;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] reg_data1_in, reg_data2_in, sign_ext_in;
    logic [3:0]  rs_in, rt_in, rd_in;
    logic [2:0]  alu_control_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, alu_src_in;
    logic [15:0] reg_data1_out, reg_data2_out, sign_ext_out;
    logic [3:0]  rs_out, rt_out, rd_out;
    logic [2:0]  alu_control_out;
    logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_src_out;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage_buf dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_data1_in(reg_data1_in), .reg_data2_in(reg_data2_in), .sign_ext_in(sign_ext_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .alu_control_in(alu_control_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .alu_src_in(alu_src_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_data1_out(reg_data1_out), .reg_data2_out(reg_data2_out), .sign_ext_out(sign_ext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .alu_control_out(alu_control_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .mem_to_reg_out(mem_to_reg_out), .alu_src_out(alu_src_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [15:0] d1;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [15:0] e_d1;
        logic [3:0]  e_rd;
        logic        e_rw;
        logic        e_mw;
    } vec_t;

    vec_t vecs[$];

    // The other payload fields are derived from data1 so one value identifies a whole instruction.
    function automatic logic [15:0] d2_of(input logic [15:0] d1);
        return ~d1;
    endfunction
    function automatic logic [15:0] se_of(input logic [15:0] d1);
        return {d1[7:0], d1[15:8]};
    endfunction
    function automatic logic [3:0] rs_of(input logic [15:0] d1);
        return d1[3:0] ^ 4'h5;
    endfunction
    function automatic logic [3:0] rt_of(input logic [15:0] d1);
        return d1[7:4];
    endfunction
    function automatic logic [2:0] alu_of(input logic [15:0] d1);
        return d1[10:8];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic iv, input logic ordy,
                         input logic [15:0] d1, input logic [3:0] rd, input logic rw, input logic mw);
        reset          = rst_n;
        flush          = fl;
        in_valid       = iv;
        out_ready      = ordy;
        reg_data1_in   = d1;
        reg_data2_in   = d2_of(d1);
        sign_ext_in    = se_of(d1);
        rs_in          = rs_of(d1);
        rt_in          = rt_of(d1);
        rd_in          = rd;
        alu_control_in = alu_of(d1);
        reg_write_in   = rw;
        mem_read_in    = rw;
        mem_write_in   = mw;
        mem_to_reg_in  = mw;
        alu_src_in     = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {reg_data1_out, reg_data2_out, sign_ext_out, rs_out, rt_out, rd_out,
                     alu_control_out, reg_write_out, mem_read_out, mem_write_out,
                     mem_to_reg_out, alu_src_out, out_valid, occupancy}, '0);
    endtask

    function automatic vec_t mk(input string name, input logic rst_n, input logic fl,
                                input logic iv, input logic ordy, input logic [15:0] d1,
                                input logic [3:0] rd, input logic rw, input logic mw,
                                input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                                input logic [15:0] e_d1, input logic [3:0] e_rd,
                                input logic e_rw, input logic e_mw);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.ordy = ordy;
        v.d1 = d1; v.rd = rd; v.rw = rw; v.mw = mw;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_d1 = e_d1;
        v.e_rd = e_rd; v.e_rw = e_rw; v.e_mw = e_mw;
        return v;
    endfunction

    initial begin
        logic [15:0] exp_q[$];
        logic [7:0]  rdy_pat;
        int          sent, recv;
        logic [15:0] exp_d1;

        //            name          rst fl iv rdy d1        rd    rw mw | ov ir occ e_d1     e_rd  rw mw
        vecs.push_back(mk("reset0",     0, 0, 1, 1, 16'h0011, 4'h1, 1, 1,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("reset1",     0, 0, 1, 1, 16'h0011, 4'h1, 1, 1,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("stream1",    1, 0, 1, 1, 16'h0011, 4'h1, 1, 0,  1, 1, 1, 16'h0011, 4'h1, 1, 0));
        vecs.push_back(mk("stream2",    1, 0, 1, 1, 16'h0022, 4'h2, 0, 1,  1, 1, 1, 16'h0022, 4'h2, 0, 1));
        vecs.push_back(mk("stream3",    1, 0, 1, 1, 16'h0033, 4'h3, 1, 1,  1, 1, 1, 16'h0033, 4'h3, 1, 1));
        vecs.push_back(mk("stream4",    1, 0, 1, 1, 16'h0044, 4'h4, 0, 0,  1, 1, 1, 16'h0044, 4'h4, 0, 0));
        vecs.push_back(mk("stream_end", 1, 0, 0, 1, 16'h0000, 4'h0, 0, 0,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("bp_a",       1, 0, 1, 0, 16'hAAAA, 4'hA, 1, 1,  1, 1, 1, 16'hAAAA, 4'hA, 1, 1));
        vecs.push_back(mk("bp_b_full",  1, 0, 1, 0, 16'hBBBB, 4'hB, 1, 0,  1, 0, 2, 16'hAAAA, 4'hA, 1, 1));
        vecs.push_back(mk("bp_c_held",  1, 0, 1, 0, 16'hCCCC, 4'hC, 0, 1,  1, 0, 2, 16'hAAAA, 4'hA, 1, 1));
        vecs.push_back(mk("bp_drain_b", 1, 0, 1, 1, 16'hCCCC, 4'hC, 0, 1,  1, 1, 1, 16'hBBBB, 4'hB, 1, 0));
        vecs.push_back(mk("bp_drain_c", 1, 0, 1, 1, 16'hCCCC, 4'hC, 0, 1,  1, 1, 1, 16'hCCCC, 4'hC, 0, 1));
        vecs.push_back(mk("bp_empty",   1, 0, 0, 1, 16'h0000, 4'h0, 0, 0,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("fl_fill1",   1, 0, 1, 0, 16'h1111, 4'h1, 1, 1,  1, 1, 1, 16'h1111, 4'h1, 1, 1));
        vecs.push_back(mk("fl_fill2",   1, 0, 1, 0, 16'h2222, 4'h2, 1, 1,  1, 0, 2, 16'h1111, 4'h1, 1, 1));
        vecs.push_back(mk("fl_full",    1, 1, 1, 0, 16'h7777, 4'h7, 1, 1,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("fl_after",   1, 0, 0, 1, 16'h0000, 4'h0, 0, 0,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("fl_one_ld",  1, 0, 1, 1, 16'h5555, 4'h5, 1, 1,  1, 1, 1, 16'h5555, 4'h5, 1, 1));
        vecs.push_back(mk("fl_one",     1, 1, 1, 1, 16'h7777, 4'h7, 1, 1,  0, 1, 0, 16'h0000, 4'h0, 0, 0));
        vecs.push_back(mk("fl_one_aft", 1, 0, 0, 1, 16'h0000, 4'h0, 0, 0,  0, 1, 0, 16'h0000, 4'h0, 0, 0));

        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].ordy,
                  vecs[i].d1, vecs[i].rd, vecs[i].rw, vecs[i].mw);
            @(negedge clk);
            check({vecs[i].name, ".out_valid"}, out_valid, vecs[i].e_ov);
            check({vecs[i].name, ".in_ready"},  in_ready,  vecs[i].e_ir);
            check({vecs[i].name, ".occupancy"}, occupancy, vecs[i].e_occ);
            check({vecs[i].name, ".ctrl"}, {reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out},
                  {vecs[i].e_rw, vecs[i].e_rw, vecs[i].e_mw, vecs[i].e_mw});
            if (!vecs[i].rst_n) check_all_zero({vecs[i].name, ".zero"});
            if (vecs[i].e_ov) begin
                check({vecs[i].name, ".payload"},
                      {reg_data1_out, reg_data2_out, sign_ext_out, rs_out, rt_out, rd_out,
                       alu_control_out, alu_src_out},
                      {vecs[i].e_d1, d2_of(vecs[i].e_d1), se_of(vecs[i].e_d1), rs_of(vecs[i].e_d1),
                       rt_of(vecs[i].e_d1), vecs[i].e_rd, alu_of(vecs[i].e_d1), 1'b1});
            end
        end

        // Reset in the middle of a stall must discard both held entries.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hD1D1, 4'hD, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hD2D2, 4'hE, 1'b1, 1'b1);
        @(negedge clk);
        check("rst_stall.occupancy", occupancy, 2'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hD3D3, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        check("rst_stall.in_ready", in_ready, 1'b1);
        check_all_zero("rst_stall.zero");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 4'h9, 1'b1, 1'b0);
        @(negedge clk);
        check("resume.out_valid", out_valid, 1'b1);
        check("resume.data", {reg_data1_out, rd_out, reg_write_out, mem_write_out},
              {16'h1234, 4'h9, 1'b1, 1'b0});
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("resume.drained", {out_valid, occupancy}, 3'b000);

        // FIFO order under an irregular out_ready pattern, bounded by a cycle budget.
        rdy_pat = 8'b1011_0010;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 6; cyc++) begin
            drive(1'b1, 1'b0, sent < 6, rdy_pat[cyc % 8], 16'h0100 + 16'(sent), 4'(sent), 1'b0, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("fifo.spurious", reg_data1_out, 16'hFFFF);
                end else begin
                    exp_d1 = exp_q.pop_front();
                    check("fifo.order", reg_data1_out, exp_d1);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(reg_data1_in);
                sent++;
            end
            @(negedge clk);
        end
        check("fifo.count", recv, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
